// File: rtl/egress_reader.sv
// egress_reader: per-port circular buffers draining switch egress words
// to an Avalon-MM slave, with status, sticky error flags and drop counter.
module egress_reader #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [3:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             readdatavalid,
  input  logic [WIDTH-1:0] out_data1,
  input  logic [WIDTH-1:0] out_data2,
  input  logic [WIDTH-1:0] out_data3,
  input  logic             out_wr1,
  input  logic             out_wr2,
  input  logic             out_wr3,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int NP = 3;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [WIDTH-1:0] din [NP];
  logic [NP-1:0]    wr_v;

  logic [WIDTH-1:0] mem_q [NP][DEPTH];
  ptr_t             wptr_q [NP];
  ptr_t             wptr_d [NP];
  ptr_t             rptr_q [NP];
  ptr_t             rptr_d [NP];
  cnt_t             cnt_q [NP];
  cnt_t             cnt_d [NP];
  logic [NP-1:0]    ovf_q;
  logic [NP-1:0]    ovf_d;
  logic [NP-1:0]    udf_q;
  logic [NP-1:0]    udf_d;
  logic [31:0]      drop_q;
  logic [31:0]      drop_d;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_d;
  logic             rvalid_q;
  logic             irq_q;
  logic             irq_d;

  logic             rd_en;
  logic             clr;
  logic [NP-1:0]    nempty;
  logic [NP-1:0]    full;
  logic [NP-1:0]    pop;
  logic [NP-1:0]    acc;
  logic [NP-1:0]    drop;
  logic [NP-1:0]    udf_ev;
  logic [WIDTH-1:0] head [NP];
  logic [31:0]      status;
  logic [31:0]      port_word;
  logic [1:0]       ndrop;
  logic [32:0]      drop_sum;
  logic             any_d;
  logic             unused_wd;

  assign din[0] = out_data1;
  assign din[1] = out_data2;
  assign din[2] = out_data3;
  assign wr_v   = {out_wr3, out_wr2, out_wr1};

  assign unused_wd = ^writedata;

  always_comb begin
    rd_en     = chipselect & read;
    clr       = chipselect & write & (address == 4'd4);
    status    = '0;
    port_word = '0;
    ndrop     = '0;
    any_d     = 1'b0;
    for (int p = 0; p < NP; p++) begin
      nempty[p] = cnt_q[p] != '0;
      full[p]   = cnt_q[p] == cnt_t'(DEPTH);
      head[p]   = mem_q[p][rptr_q[p]];
      pop[p]    = rd_en && (address == 4'(p + 1)) && nempty[p];
      udf_ev[p] = rd_en && (address == 4'(p + 1)) && !nempty[p];
      // a pop in the same cycle frees the slot a full-buffer push needs
      acc[p]    = wr_v[p] && (!full[p] || pop[p]);
      drop[p]   = wr_v[p] && full[p] && !pop[p];
      cnt_d[p]  = cnt_q[p] + cnt_t'(acc[p]) - cnt_t'(pop[p]);
      wptr_d[p] = wptr_q[p] + ptr_t'(acc[p]);
      rptr_d[p] = rptr_q[p] + ptr_t'(pop[p]);
      ovf_d[p]  = (ovf_q[p] && !clr) || drop[p];
      udf_d[p]  = (udf_q[p] && !clr) || udf_ev[p];
      ndrop     = ndrop + 2'(drop[p]);
      any_d     = any_d || (cnt_d[p] != '0);
      status[8*p +: CW] = cnt_q[p];
      status[24 + p]    = !nempty[p];
      status[27 + p]    = ovf_q[p];
      if ((address == 4'(p + 1)) && nempty[p]) begin
        port_word = 32'(head[p]);
      end
    end
    status[30] = |udf_q;

    drop_sum = (clr ? 33'd0 : {1'b0, drop_q}) + 33'(ndrop);
    drop_d   = drop_sum[32] ? '1 : drop_sum[31:0];
    irq_d    = any_d || (|ovf_d) || (|udf_d);

    unique case (1'b1)
      address == 4'd0:
        rdata_d = status;
      (address >= 4'd1) && (address <= 4'd3):
        rdata_d = port_word;
      address == 4'd4:
        rdata_d = drop_q;
      default:
        rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        wptr_q[p] <= '0;
        rptr_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
      ovf_q    <= '0;
      udf_q    <= '0;
      drop_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        wptr_q[p] <= wptr_d[p];
        rptr_q[p] <= rptr_d[p];
        cnt_q[p]  <= cnt_d[p];
      end
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      drop_q   <= drop_d;
      rvalid_q <= rd_en;
      irq_q    <= irq_d;
      if (rd_en) begin
        rdata_q <= rdata_d;
      end
    end
  end

  // storage carries no reset; occupancy alone defines valid contents
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        mem_q[p][wptr_q[p]] <= din[p];
      end
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;
  assign irq           = irq_q;

endmodule
